gs_ddram_arb: RTL and testbench

//  Shares the DDR3 Avalon port between two byte-wide requesters of the General Sound memory:

---
 rtl/gs_ddram_pkg.sv | 26 ++
 rtl/gs_ddram_arb_if.sv | 34 +++
 rtl/gs_ddram_line.sv | 42 ++++
 rtl/gs_ddram_arb.sv | 189 ++++++++++++++++++
 tb/tb_gs_ddram_arb.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gs_ddram_pkg.sv
// Shared types and constants for the General Sound DDR3 arbiter.
package gs_ddram_pkg;

    localparam int LINE_W   = 64;
    localparam int WORD_OFS = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_CMD,
        RD_WAIT,
        RD_HIT,
        WR_CMD,
        DRAIN
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    function automatic logic [7:0] line_byte(input logic [LINE_W-1:0] line,
                                             input logic [WORD_OFS-1:0] ofs);
        return line[{ofs, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/gs_ddram_arb_if.sv
// Requester ports A/B and DDR3 Avalon pins of the GS memory arbiter.
interface gs_ddram_arb_if #(
    parameter int AW = 21
);
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_din, b_din;
    logic          a_rd, b_rd, a_we, b_we;
    logic [7:0]    a_dout, b_dout;
    logic          a_ready, b_ready;

    logic          DDRAM_BUSY;
    logic [63:0]   DDRAM_DOUT;
    logic          DDRAM_DOUT_READY;
    logic [28:0]   DDRAM_ADDR;
    logic [7:0]    DDRAM_BURSTCNT;
    logic          DDRAM_RD, DDRAM_WE;
    logic [63:0]   DDRAM_DIN;
    logic [7:0]    DDRAM_BE;

    modport slave (
        input  a_addr, b_addr, a_din, b_din, a_rd, b_rd, a_we, b_we,
        output a_dout, b_dout, a_ready, b_ready,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

    modport master (
        output a_addr, b_addr, a_din, b_din, a_rd, b_rd, a_we, b_we,
        input  a_dout, b_dout, a_ready, b_ready,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_RD, DDRAM_WE, DDRAM_DIN, DDRAM_BE
    );

endinterface

// File: rtl/gs_ddram_line.sv
// Single 64-bit read line for the GS arbiter (used with GS_DDRAM_LINEBUF_EN):
// tag/valid/data storage, hit compare and write-through byte merge.
module gs_ddram_line
    import gs_ddram_pkg::*;
#(
    parameter int TAG_W = 18
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic [TAG_W-1:0]    i_tag,
    output logic                o_hit,
    output logic [LINE_W-1:0]   o_data,
    input  logic                i_fill,
    input  logic [TAG_W-1:0]    i_fill_tag,
    input  logic [LINE_W-1:0]   i_fill_data,
    input  logic                i_wr,
    input  logic [TAG_W-1:0]    i_wr_tag,
    input  logic [WORD_OFS-1:0] i_wr_ofs,
    input  logic [7:0]          i_wr_byte
);

    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [LINE_W-1:0] r_data;

    assign o_hit  = r_valid && (r_tag == i_tag);
    assign o_data = r_data;

    // NOTE: only the valid bit is reset; tag and data are don't-care while invalid.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_valid <= 1'b1;
            r_tag   <= i_fill_tag;
            r_data  <= i_fill_data;
        end else if (i_wr && r_valid && (r_tag == i_wr_tag)) begin
            r_data[{i_wr_ofs, 3'b000} +: 8] <= i_wr_byte;
        end
    end

endmodule

// File: rtl/gs_ddram_arb.sv
// Round-robin byte-to-64-bit arbiter between GS CPU (A) and HPS loader (B) on DDR3.
// Optional read line buffer enabled by defining GS_DDRAM_LINEBUF_EN.
module gs_ddram_arb
    import gs_ddram_pkg::*;
#(
    parameter logic [28:0] BASE_WADDR = 29'h0300000,
    parameter int          AW         = 21
) (
    input  logic          clk_sys,
    input  logic          reset,
    gs_ddram_arb_if.slave bus
);

    state_t              r_state;
    port_t               r_last_tie, r_cur;
    logic                r_a_pend, r_b_pend, r_a_wr, r_b_wr;
    logic [AW-1:0]       r_a_addr, r_b_addr;
    logic [7:0]          r_a_din, r_b_din;
    logic                r_rd_outstanding;
    logic [WORD_OFS-1:0] r_ofs;
    logic [AW-WORD_OFS-1:0] r_tag;
    logic                r_a_ready, r_b_ready;
    logic [7:0]          r_a_dout, r_b_dout;
    logic                r_ddr_rd, r_ddr_we;
    logic [28:0]         r_ddr_addr;
    logic [7:0]          r_ddr_be;
    logic [LINE_W-1:0]   r_ddr_din;

    logic                w_a_strobe, w_b_strobe, w_grant_valid, w_sel_wr, w_hit;
    port_t               w_grant;
    logic [AW-1:0]       w_sel_addr;
    logic [7:0]          w_sel_din;
    logic [LINE_W-1:0]   w_line;

    assign w_a_strobe = (bus.a_rd | bus.a_we) & r_a_ready;
    assign w_b_strobe = (bus.b_rd | bus.b_we) & r_b_ready;

    // Ties go to the port that lost the previous tie; r_last_tie only moves on ties.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_grant_valid = r_a_pend | r_b_pend;
        w_grant       = PORT_A;
        if (r_a_pend && r_b_pend)
            w_grant = (r_last_tie == PORT_A) ? PORT_B : PORT_A;
        else if (r_b_pend)
            w_grant = PORT_B;
    end

    assign w_sel_addr = (w_grant == PORT_B) ? r_b_addr : r_a_addr;
    assign w_sel_din  = (w_grant == PORT_B) ? r_b_din  : r_a_din;
    assign w_sel_wr   = (w_grant == PORT_B) ? r_b_wr   : r_a_wr;

`ifdef GS_DDRAM_LINEBUF_EN
    gs_ddram_line #(.TAG_W(AW-WORD_OFS)) u_line (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_tag       (w_sel_addr[AW-1:WORD_OFS]),
        .o_hit       (w_hit),
        .o_data      (w_line),
        .i_fill      (r_state == RD_WAIT && bus.DDRAM_DOUT_READY),
        .i_fill_tag  (r_tag),
        .i_fill_data (bus.DDRAM_DOUT),
        .i_wr        (r_state == IDLE && w_grant_valid && w_sel_wr),
        .i_wr_tag    (w_sel_addr[AW-1:WORD_OFS]),
        .i_wr_ofs    (w_sel_addr[WORD_OFS-1:0]),
        .i_wr_byte   (w_sel_din)
    );
`else
    assign w_hit  = 1'b0;
    assign w_line = '0;
`endif

    // NOTE: deliberately outside any reset: a read already accepted by DDR3 still returns data.
    always_ff @(posedge clk_sys) begin
        if (r_state == RD_CMD && !bus.DDRAM_BUSY)
            r_rd_outstanding <= 1'b1;
        else if (bus.DDRAM_DOUT_READY)
            r_rd_outstanding <= 1'b0;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= r_rd_outstanding ? DRAIN : IDLE;
            r_last_tie <= PORT_B;
            r_cur      <= PORT_A;
            r_a_pend   <= 1'b0;
            r_b_pend   <= 1'b0;
            r_a_wr     <= 1'b0;
            r_b_wr     <= 1'b0;
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_a_din    <= '0;
            r_b_din    <= '0;
            r_ofs      <= '0;
            r_tag      <= '0;
            r_a_ready  <= 1'b1;
            r_b_ready  <= 1'b1;
            r_a_dout   <= '0;
            r_b_dout   <= '0;
            r_ddr_rd   <= 1'b0;
            r_ddr_we   <= 1'b0;
            r_ddr_addr <= BASE_WADDR;
            r_ddr_be   <= '0;
            r_ddr_din  <= '0;
        end else begin
            if (w_a_strobe) begin
                r_a_pend  <= 1'b1;
                r_a_ready <= 1'b0;
                r_a_addr  <= bus.a_addr;
                r_a_din   <= bus.a_din;
                r_a_wr    <= bus.a_we;
            end
            if (w_b_strobe) begin
                r_b_pend  <= 1'b1;
                r_b_ready <= 1'b0;
                r_b_addr  <= bus.b_addr;
                r_b_din   <= bus.b_din;
                r_b_wr    <= bus.b_we;
            end

            case (r_state)
                IDLE: if (w_grant_valid) begin
                    r_cur      <= w_grant;
                    r_ofs      <= w_sel_addr[WORD_OFS-1:0];
                    r_tag      <= w_sel_addr[AW-1:WORD_OFS];
                    r_ddr_addr <= BASE_WADDR + 29'(w_sel_addr[AW-1:WORD_OFS]);
                    r_ddr_be   <= 8'b1 << w_sel_addr[WORD_OFS-1:0];
                    r_ddr_din  <= {8{w_sel_din}};
                    if (r_a_pend && r_b_pend) r_last_tie <= w_grant;
                    if (w_grant == PORT_A) r_a_pend <= 1'b0;
                    else                   r_b_pend <= 1'b0;
                    if (w_sel_wr) begin
                        r_ddr_we <= 1'b1;
                        r_state  <= WR_CMD;
                    end else if (w_hit) begin
                        r_state  <= RD_HIT;
                    end else begin
                        r_ddr_rd <= 1'b1;
                        r_state  <= RD_CMD;
                    end
                end
                WR_CMD: if (!bus.DDRAM_BUSY) begin
                    r_ddr_we <= 1'b0;
                    if (r_cur == PORT_A) r_a_ready <= 1'b1;
                    else                 r_b_ready <= 1'b1;
                    r_state <= IDLE;
                end
                RD_CMD: if (!bus.DDRAM_BUSY) begin
                    r_ddr_rd <= 1'b0;
                    r_state  <= RD_WAIT;
                end
                RD_WAIT: if (bus.DDRAM_DOUT_READY) begin
                    if (r_cur == PORT_A) begin
                        r_a_dout  <= line_byte(bus.DDRAM_DOUT, r_ofs);
                        r_a_ready <= 1'b1;
                    end else begin
                        r_b_dout  <= line_byte(bus.DDRAM_DOUT, r_ofs);
                        r_b_ready <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                RD_HIT: begin
                    if (r_cur == PORT_A) begin
                        r_a_dout  <= line_byte(w_line, r_ofs);
                        r_a_ready <= 1'b1;
                    end else begin
                        r_b_dout  <= line_byte(w_line, r_ofs);
                        r_b_ready <= 1'b1;
                    end
                    r_state <= IDLE;
                end
                DRAIN: if (bus.DDRAM_DOUT_READY) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.a_dout         = r_a_dout;
    assign bus.b_dout         = r_b_dout;
    assign bus.a_ready        = r_a_ready;
    assign bus.b_ready        = r_b_ready;
    assign bus.DDRAM_ADDR     = r_ddr_addr;
    assign bus.DDRAM_BURSTCNT = 8'd1;
    assign bus.DDRAM_RD       = r_ddr_rd;
    assign bus.DDRAM_WE       = r_ddr_we;
    assign bus.DDRAM_DIN      = r_ddr_din;
    assign bus.DDRAM_BE       = r_ddr_be;

endmodule

// File: tb/tb_gs_ddram_arb.sv
// Directed bench for gs_ddram_arb; the line-buffer scenario runs when GS_DDRAM_LINEBUF_EN is defined.
module tb_gs_ddram_arb;

    localparam logic [28:0] BASE = 29'h0300000;

    logic clk_sys = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    gs_ddram_arb_if #(.AW(21)) bus ();

    gs_ddram_arb #(.BASE_WADDR(BASE), .AW(21)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic req_a(input logic wr, input logic [20:0] addr, input logic [7:0] din);
        bus.a_addr = addr;
        bus.a_din  = din;
        bus.a_we   = wr;
        bus.a_rd   = ~wr;
    endtask

    task automatic req_b(input logic wr, input logic [20:0] addr, input logic [7:0] din);
        bus.b_addr = addr;
        bus.b_din  = din;
        bus.b_we   = wr;
        bus.b_rd   = ~wr;
    endtask

    task automatic idle_strobes();
        bus.a_rd = 1'b0;
        bus.a_we = 1'b0;
        bus.b_rd = 1'b0;
        bus.b_we = 1'b0;
    endtask

    task automatic ddr_reply(input logic [63:0] d);
        bus.DDRAM_DOUT       = d;
        bus.DDRAM_DOUT_READY = 1'b1;
        cyc(1);
        bus.DDRAM_DOUT_READY = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_ready"}, bus.a_ready, 1);
        check({tag, "_b_ready"}, bus.b_ready, 1);
        check({tag, "_a_dout"}, bus.a_dout, 0);
        check({tag, "_b_dout"}, bus.b_dout, 0);
        check({tag, "_rd_we"}, {bus.DDRAM_RD, bus.DDRAM_WE}, 0);
        check({tag, "_addr"}, bus.DDRAM_ADDR, BASE);
        check({tag, "_be"}, bus.DDRAM_BE, 0);
        check({tag, "_din"}, bus.DDRAM_DIN, 0);
        check({tag, "_burstcnt"}, bus.DDRAM_BURSTCNT, 1);
    endtask

    initial begin
        int we_hi;
        int rd_hi;
        int stable;

        reset = 1'b1;
        idle_strobes();
        bus.a_addr = '0;
        bus.b_addr = '0;
        bus.a_din  = '0;
        bus.b_din  = '0;
        bus.DDRAM_BUSY       = 1'b0;
        bus.DDRAM_DOUT       = '0;
        bus.DDRAM_DOUT_READY = 1'b0;
        cyc(3);
        reset = 1'b0;
        check_reset_state("rst");

        // 1: A write 0x00005 = 0xA5
        req_a(1'b1, 21'h00005, 8'hA5);
        cyc(1);
        idle_strobes();
        check("t1_ready_drop", bus.a_ready, 0);
        cyc(1);
        check("t1_we", bus.DDRAM_WE, 1);
        check("t1_addr", bus.DDRAM_ADDR, BASE);
        check("t1_be", bus.DDRAM_BE, 8'h20);
        check("t1_din", bus.DDRAM_DIN, 64'hA5A5_A5A5_A5A5_A5A5);
        cyc(1);
        check("t1_we_one_cycle", bus.DDRAM_WE, 0);
        check("t1_ready_back", bus.a_ready, 1);

        // 2: A read 0x00005, byte 5 of the returned word
        req_a(1'b0, 21'h00005, 8'h00);
        cyc(1);
        idle_strobes();
        cyc(1);
        check("t2_rd", bus.DDRAM_RD, 1);
        check("t2_addr", bus.DDRAM_ADDR, BASE);
        cyc(1);
        check("t2_rd_drop", bus.DDRAM_RD, 0);
        cyc(8);
        check("t2_still_busy", bus.a_ready, 0);
        ddr_reply(64'h1122_A544_5566_7788);
        check("t2_dout", bus.a_dout, 8'hA5);
        check("t2_ready", bus.a_ready, 1);

        // 3: tie -> A first, then B; next tie -> B first
        req_a(1'b1, 21'h00100, 8'h11);
        req_b(1'b1, 21'h00208, 8'h22);
        cyc(1);
        idle_strobes();
        cyc(1);
        check("t3_first_addr_a", bus.DDRAM_ADDR, BASE + 29'h20);
        check("t3_first_din_a", bus.DDRAM_DIN, 64'h1111_1111_1111_1111);
        cyc(1);
        check("t3_a_done", {bus.a_ready, bus.b_ready}, 2'b10);
        cyc(1);
        check("t3_second_we", bus.DDRAM_WE, 1);
        check("t3_second_addr_b", bus.DDRAM_ADDR, BASE + 29'h41);
        cyc(1);
        check("t3_b_done", {bus.a_ready, bus.b_ready}, 2'b11);
        req_a(1'b1, 21'h00018, 8'h33);
        req_b(1'b1, 21'h0000F, 8'h44);
        cyc(1);
        idle_strobes();
        cyc(1);
        check("t3_tie2_addr_b", bus.DDRAM_ADDR, BASE + 29'h1);
        check("t3_tie2_be_b", bus.DDRAM_BE, 8'h80);
        cyc(2);
        check("t3_tie2_addr_a", bus.DDRAM_ADDR, BASE + 29'h3);
        check("t3_tie2_be_a", bus.DDRAM_BE, 8'h01);
        cyc(1);
        check("t3_tie2_done", {bus.a_ready, bus.b_ready}, 2'b11);

        // 3c: B strobes on the very edge A's write completes
        req_a(1'b1, 21'h00020, 8'h66);
        cyc(1);
        idle_strobes();
        cyc(1);
        req_b(1'b1, 21'h00038, 8'h55);
        cyc(1);
        idle_strobes();
        check("t3c_overlap_ready", {bus.a_ready, bus.b_ready}, 2'b10);
        cyc(1);
        check("t3c_b_we", bus.DDRAM_WE, 1);
        check("t3c_b_addr", bus.DDRAM_ADDR, BASE + 29'h7);
        cyc(1);
        check("t3c_b_done", bus.b_ready, 1);

        // 4: BUSY high for 5 clocks during a write
        bus.DDRAM_BUSY = 1'b1;
        req_a(1'b1, 21'h001F3, 8'h5A);
        cyc(1);
        idle_strobes();
        cyc(1);
        we_hi  = 0;
        stable = 1;
        for (int i = 0; i < 6; i++) begin
            if (bus.DDRAM_WE === 1'b1) we_hi++;
            if (bus.DDRAM_ADDR !== BASE + 29'h3E || bus.DDRAM_BE !== 8'h08) stable = 0;
            if (i == 5) bus.DDRAM_BUSY = 1'b0;
            cyc(1);
        end
        check("t4_we_cycles", we_hi, 6);
        check("t4_addr_be_stable", stable, 1);
        check("t4_we_drop", bus.DDRAM_WE, 0);
        check("t4_ready", bus.a_ready, 1);

        // 5: reset during RD_WAIT, stale data drained, B read served afterwards
        req_a(1'b0, 21'h0000A, 8'h00);
        cyc(1);
        idle_strobes();
        cyc(2);
        check("t5_in_rd_wait", {bus.DDRAM_RD, bus.a_ready}, 2'b00);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        check_reset_state("t5_rst");
        req_b(1'b0, 21'h00013, 8'h00);
        cyc(1);
        idle_strobes();
        check("t5_b_latched", bus.b_ready, 0);
        rd_hi = 0;
        for (int i = 0; i < 2; i++) begin
            if (bus.DDRAM_RD === 1'b1) rd_hi++;
            cyc(1);
        end
        ddr_reply(64'hDEAD_BEEF_CAFE_F00D);
        check("t5_no_rd_in_drain", rd_hi + int'(bus.DDRAM_RD), 0);
        check("t5_stale_dropped", {bus.a_dout, bus.b_dout, bus.b_ready}, 17'h0);
        cyc(1);
        check("t5_b_rd", bus.DDRAM_RD, 1);
        check("t5_b_addr", bus.DDRAM_ADDR, BASE + 29'h2);
        cyc(3);
        ddr_reply(64'h0123_4567_89AB_CDEF);
        check("t5_b_dout", bus.b_dout, 8'h89);
        check("t5_b_ready", bus.b_ready, 1);
        check("t5_a_dout_clean", bus.a_dout, 0);

`ifdef GS_DDRAM_LINEBUF_EN
        // 6: read 0x10, write 0x11 = 0x3C, read 0x11 hits the merged line
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        req_a(1'b0, 21'h00010, 8'h00);
        cyc(1);
        idle_strobes();
        cyc(2);
        ddr_reply(64'h8877_6655_4433_2211);
        check("t6_fill_dout", bus.a_dout, 8'h11);
        req_a(1'b1, 21'h00011, 8'h3C);
        cyc(1);
        idle_strobes();
        cyc(1);
        check("t6_wr_through", {bus.DDRAM_WE, bus.DDRAM_BE}, {1'b1, 8'h02});
        cyc(1);
        req_a(1'b0, 21'h00011, 8'h00);
        cyc(1);
        idle_strobes();
        cyc(1);
        check("t6_hit_no_rd", bus.DDRAM_RD, 0);
        cyc(1);
        check("t6_hit_no_rd2", bus.DDRAM_RD, 0);
        check("t6_hit_ready", bus.a_ready, 1);
        check("t6_hit_dout", bus.a_dout, 8'h3C);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
